// File: rtl/aes_gcm_job_sequencer_if.sv
// aes_gcm_job_sequencer_if: job/data/slot bundle between a job issuer (master) and the sequencer (slave).
// AES_SEQ_STALL_CNT_EN adds o_stall_count.
interface aes_gcm_job_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             i_start;
   logic [1407:0]    i_key_schedule;
   logic [95:0]      i_iv;
   logic [CNT_W-1:0] i_aad_blocks;
   logic [CNT_W-1:0] i_pt_blocks;
   logic             i_data_valid;
   logic [127:0]     i_data;
   logic             o_data_ready;
   logic             o_busy;
   logic             o_done;
   logic [2:0]       o_phase;
   logic [127:0]     o_h;
   logic [127:0]     o_j0;
   logic [127:0]     o_cb;
   logic [127:0]     o_aad;
   logic [127:0]     o_plain_text;
   logic [1407:0]    o_key_schedule;
   logic [127:0]     o_instance_size;
`ifdef AES_SEQ_STALL_CNT_EN
   logic [31:0]      o_stall_count;
`endif

   modport slave (
      input  i_start, i_key_schedule, i_iv, i_aad_blocks, i_pt_blocks, i_data_valid, i_data,
      output o_data_ready, o_busy, o_done, o_phase, o_h, o_j0, o_cb, o_aad, o_plain_text, o_key_schedule,
`ifdef AES_SEQ_STALL_CNT_EN
      output o_instance_size, o_stall_count
`else
      output o_instance_size
`endif
   );

   modport master (
      output i_start, i_key_schedule, i_iv, i_aad_blocks, i_pt_blocks, i_data_valid, i_data,
      input  o_data_ready, o_busy, o_done, o_phase, o_h, o_j0, o_cb, o_aad, o_plain_text, o_key_schedule,
`ifdef AES_SEQ_STALL_CNT_EN
      input  o_instance_size, o_stall_count
`else
      input  o_instance_size
`endif
   );
endinterface

// File: rtl/aes_gcm_job_sequencer.sv
// aes_gcm_job_sequencer: issues INIT/AAD/PT/LEN slots for one AES-GCM job, then waits out the pipeline.
// Optional AES_SEQ_STALL_CNT_EN counts input-starved cycles in AAD/PT.
module aes_gcm_job_sequencer #(
   parameter int CNT_W      = 16,
   parameter int PIPE_DEPTH = 10
) (
   input logic                   clk,
   input logic                   rst,
   aes_gcm_job_sequencer_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_AAD   = 3'd2;
   localparam logic [2:0] S_PT    = 3'd3;
   localparam logic [2:0] S_LEN   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam int DW = $clog2(PIPE_DEPTH + 2);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH);

   logic [2:0]       state;
   logic [CNT_W-1:0] aad_left;
   logic [CNT_W-1:0] pt_left;
   logic [127:0]     cb;
   logic [DW-1:0]    drain_cnt;

   assign bus.o_busy       = state != S_IDLE;
   assign bus.o_data_ready = state == S_AAD || state == S_PT;
   assign bus.o_h          = '0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state                <= S_IDLE;
         aad_left             <= '0;
         pt_left              <= '0;
         cb                   <= '0;
         drain_cnt            <= '0;
         bus.o_done           <= 1'b0;
         bus.o_phase          <= 3'd0;
         bus.o_j0             <= '0;
         bus.o_cb             <= '0;
         bus.o_aad            <= '0;
         bus.o_plain_text     <= '0;
         bus.o_key_schedule   <= '0;
         bus.o_instance_size  <= '0;
      end else begin
         bus.o_phase <= 3'd0;
         bus.o_done  <= 1'b0;
         case (state)
            S_IDLE: if (bus.i_start) begin
               bus.o_key_schedule  <= bus.i_key_schedule;
               bus.o_j0            <= {bus.i_iv, 32'h1};
               cb                  <= {bus.i_iv, 32'h2};
               bus.o_instance_size <= {{(57-CNT_W){1'b0}}, bus.i_aad_blocks, 7'd0,
                                       {(57-CNT_W){1'b0}}, bus.i_pt_blocks, 7'd0};
               aad_left            <= bus.i_aad_blocks;
               pt_left             <= bus.i_pt_blocks;
               state               <= S_INIT;
            end
            S_INIT: begin
               bus.o_phase <= 3'd1;
               state       <= aad_left != '0 ? S_AAD : pt_left != '0 ? S_PT : S_LEN;
            end
            S_AAD: if (bus.i_data_valid) begin
               bus.o_phase <= 3'd2;
               bus.o_aad   <= bus.i_data;
               aad_left    <= aad_left - CNT_W'(1);
               if (aad_left == CNT_W'(1)) state <= pt_left != '0 ? S_PT : S_LEN;
            end
            S_PT: if (bus.i_data_valid) begin
               bus.o_phase      <= 3'd3;
               bus.o_plain_text <= bus.i_data;
               bus.o_cb         <= cb;
               cb               <= {cb[127:32], cb[31:0] + 32'd1};
               pt_left          <= pt_left - CNT_W'(1);
               if (pt_left == CNT_W'(1)) state <= S_LEN;
            end
            S_LEN: begin
               bus.o_phase <= 3'd4;
               drain_cnt   <= '0;
               state       <= S_DRAIN;
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt + DW'(1);
               if (drain_cnt == DRAIN_LAST) begin
                  bus.o_done <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end

`ifdef AES_SEQ_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) bus.o_stall_count <= '0;
      else if (state == S_IDLE && bus.i_start) bus.o_stall_count <= '0;
      else if (bus.o_data_ready && !bus.i_data_valid && bus.o_stall_count != '1)
         bus.o_stall_count <= bus.o_stall_count + 32'd1;
`endif
endmodule

// File: tb/tb_aes_gcm_job_sequencer.sv
// tb_aes_gcm_job_sequencer: directed scenario tasks for the AES-GCM job sequencer.
module tb_aes_gcm_job_sequencer;
   localparam int PD = 10;
   localparam logic [1407:0] K1 = {11{128'h00112233445566778899AABBCCDDEEFF}};
   localparam logic [1407:0] K2 = {11{128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0}};
   localparam logic [95:0] IV0 = 96'hCAFEBABE_FACEDBAD_DECAF888;
   localparam logic [95:0] IV2 = 96'h11223344_55667788_99AABBCC;
   localparam logic [95:0] IV3 = 96'hDEADBEEF_01234567_89ABCDEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [2:0]    ph_q[$];
   logic [2:0]    exp_ph[$];
   logic [127:0]  cb_q[$];
   logic [127:0]  aad_q[$];
   logic [127:0]  pt_q[$];
   logic          rdy_q[$];
   logic [127:0]  snap_j0, snap_isz, wrap_val;
   logic [1407:0] snap_key;
   int done_gap, done_pulses;

   always #5 clk = ~clk;

   aes_gcm_job_sequencer_if #(.CNT_W(16)) bus();
   aes_gcm_job_sequencer #(.CNT_W(16), .PIPE_DEPTH(PD)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Starts a job, feeds AAD (A0+i) then PT (B0+i) with optional gaps, records every cycle up to LEN,
   // then watches the drain window for o_done.
   task automatic run_job(input logic [95:0] iv, input logic [1407:0] key, input int na, input int np,
                          input int gap, input bit pulse_start, input bit force_wrap);
      int acc_a, acc_p, gl;
      bit seen4;
      acc_a = 0; acc_p = 0; gl = 0; seen4 = 0;
      ph_q.delete(); cb_q.delete(); aad_q.delete(); pt_q.delete(); rdy_q.delete();
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_iv = iv; bus.i_key_schedule = key;
      bus.i_aad_blocks = 16'(na); bus.i_pt_blocks = 16'(np); bus.i_data_valid = 1'b0;
      @(negedge clk);
      bus.i_start = 1'b0;
      if (force_wrap) begin
         force dut.cb = wrap_val;
         #1;
         release dut.cb;
      end
      for (int c = 0; c < 200 && !seen4; c++) begin
         @(negedge clk);
         ph_q.push_back(bus.o_phase); cb_q.push_back(bus.o_cb);
         aad_q.push_back(bus.o_aad); pt_q.push_back(bus.o_plain_text); rdy_q.push_back(bus.o_data_ready);
         if (bus.o_phase == 3'd4) begin
            seen4 = 1; snap_j0 = bus.o_j0; snap_isz = bus.o_instance_size; snap_key = bus.o_key_schedule;
         end
         bus.i_start = 1'b0; bus.i_data_valid = 1'b0;
         if (bus.o_data_ready) begin
            if (acc_a < na) begin
               bus.i_data_valid = 1'b1; bus.i_data = 128'hA0 + 128'(acc_a); acc_a++;
            end else if (acc_p < np) begin
               if (gl > 0) gl--;
               else begin
                  bus.i_data_valid = 1'b1; bus.i_data = 128'hB0 + 128'(acc_p); acc_p++; gl = gap;
                  if (pulse_start && acc_p == 1) begin
                     bus.i_start = 1'b1; bus.i_iv = ~iv; bus.i_key_schedule = ~key;
                     bus.i_aad_blocks = 16'd7; bus.i_pt_blocks = 16'd9;
                  end
               end
            end
         end
      end
      bus.i_start = 1'b0; bus.i_data_valid = 1'b0;
      done_gap = -1; done_pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.o_done) begin
            done_pulses++;
            if (done_gap < 0) done_gap = k;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
      checks++; if (bus.o_data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.o_data_ready); end
      checks++; if ({bus.o_phase, bus.o_done} !== 4'd0) begin failures++; $display("FAIL reset_phase_done got=%h exp=0", {bus.o_phase, bus.o_done}); end
      checks++; if (bus.o_j0 !== 128'd0 || bus.o_instance_size !== 128'd0) begin failures++; $display("FAIL reset_j0_isz got=%h/%h exp=0", bus.o_j0, bus.o_instance_size); end
      checks++; if (bus.o_key_schedule !== 1408'd0) begin failures++; $display("FAIL reset_key got=nonzero exp=0"); end
      checks++; if (bus.o_h !== 128'd0) begin failures++; $display("FAIL reset_h got=%h exp=0", bus.o_h); end
      rst = 1'b0;
   endtask

   task automatic test_zero_length();
      run_job(IV0, K1, 0, 0, 0, 1'b0, 1'b0);
      exp_ph = {3'd1, 3'd4};
      checks++; if (ph_q.size() != exp_ph.size()) begin failures++; $display("FAIL zero_phase_count got=%0d exp=%0d", ph_q.size(), exp_ph.size()); end
      foreach (exp_ph[i]) begin
         checks++;
         if (i >= ph_q.size() || ph_q[i] !== exp_ph[i]) begin failures++; $display("FAIL zero_phase[%0d] exp=%0d", i, exp_ph[i]); end
      end
      checks++; if (snap_j0 !== {IV0, 32'h1}) begin failures++; $display("FAIL zero_j0 got=%h exp=%h", snap_j0, {IV0, 32'h1}); end
      checks++; if (snap_isz !== 128'd0) begin failures++; $display("FAIL zero_isz got=%h exp=0", snap_isz); end
      checks++; if (snap_key !== K1) begin failures++; $display("FAIL zero_key got=mismatching key exp=K1"); end
      checks++; if (done_gap != PD + 1) begin failures++; $display("FAIL zero_done_gap got=%0d exp=%0d", done_gap, PD + 1); end
      checks++; if (done_pulses != 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", done_pulses); end
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL zero_idle_busy got=%b exp=0", bus.o_busy); end
   endtask

   task automatic test_back_to_back();
      run_job(IV2, K2, 2, 3, 0, 1'b0, 1'b0);
      exp_ph = {3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
      checks++; if (ph_q.size() != exp_ph.size()) begin failures++; $display("FAIL b2b_phase_count got=%0d exp=%0d", ph_q.size(), exp_ph.size()); end
      foreach (exp_ph[i]) begin
         checks++;
         if (i >= ph_q.size() || ph_q[i] !== exp_ph[i]) begin failures++; $display("FAIL b2b_phase[%0d] exp=%0d", i, exp_ph[i]); end
      end
      if (ph_q.size() == 7) begin
         checks++; if (aad_q[1] !== 128'hA0 || aad_q[2] !== 128'hA1) begin failures++; $display("FAIL b2b_aad got=%h,%h exp=a0,a1", aad_q[1], aad_q[2]); end
         checks++; if (pt_q[3] !== 128'hB0 || pt_q[4] !== 128'hB1 || pt_q[5] !== 128'hB2) begin failures++; $display("FAIL b2b_pt got=%h,%h,%h exp=b0,b1,b2", pt_q[3], pt_q[4], pt_q[5]); end
         checks++; if (cb_q[3] !== {IV2, 32'd2}) begin failures++; $display("FAIL b2b_cb0 got=%h exp=%h", cb_q[3], {IV2, 32'd2}); end
         checks++; if (cb_q[4] !== {IV2, 32'd3}) begin failures++; $display("FAIL b2b_cb1 got=%h exp=%h", cb_q[4], {IV2, 32'd3}); end
         checks++; if (cb_q[5] !== {IV2, 32'd4}) begin failures++; $display("FAIL b2b_cb2 got=%h exp=%h", cb_q[5], {IV2, 32'd4}); end
      end
      checks++; if (snap_isz !== {64'd256, 64'd384}) begin failures++; $display("FAIL b2b_isz got=%h exp=%h", snap_isz, {64'd256, 64'd384}); end
      checks++; if (done_gap != PD + 1 || done_pulses != 1) begin failures++; $display("FAIL b2b_done got=gap %0d pulses %0d exp=gap %0d pulses 1", done_gap, done_pulses, PD + 1); end
   endtask

   task automatic test_stall();
      run_job(IV2, K2, 2, 3, 2, 1'b0, 1'b0);
      exp_ph = {3'd1, 3'd2, 3'd2, 3'd3, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd3, 3'd4};
      checks++; if (ph_q.size() != exp_ph.size()) begin failures++; $display("FAIL stall_phase_count got=%0d exp=%0d", ph_q.size(), exp_ph.size()); end
      foreach (exp_ph[i]) begin
         checks++;
         if (i >= ph_q.size() || ph_q[i] !== exp_ph[i]) begin failures++; $display("FAIL stall_phase[%0d] exp=%0d", i, exp_ph[i]); end
      end
      if (ph_q.size() == 11) begin
         checks++; if ({rdy_q[4], rdy_q[5], rdy_q[7], rdy_q[8]} !== 4'b1111) begin failures++; $display("FAIL stall_ready got=%b exp=1111", {rdy_q[4], rdy_q[5], rdy_q[7], rdy_q[8]}); end
         checks++; if (cb_q[5] !== {IV2, 32'd2}) begin failures++; $display("FAIL stall_cb_hold got=%h exp=%h", cb_q[5], {IV2, 32'd2}); end
         checks++; if (cb_q[6] !== {IV2, 32'd3} || cb_q[9] !== {IV2, 32'd4}) begin failures++; $display("FAIL stall_cb got=%h,%h exp=..3,..4", cb_q[6], cb_q[9]); end
         checks++; if (pt_q[9] !== 128'hB2) begin failures++; $display("FAIL stall_pt2 got=%h exp=b2", pt_q[9]); end
      end
`ifdef AES_SEQ_STALL_CNT_EN
      checks++; if (bus.o_stall_count !== 32'd4) begin failures++; $display("FAIL stall_count got=%0d exp=4", bus.o_stall_count); end
`endif
   endtask

   task automatic test_counter_wrap();
      wrap_val = {IV3, 32'hFFFFFFFF};
      run_job(IV3, K1, 0, 2, 0, 1'b0, 1'b1);
      exp_ph = {3'd1, 3'd3, 3'd3, 3'd4};
      checks++; if (ph_q.size() != exp_ph.size()) begin failures++; $display("FAIL wrap_phase_count got=%0d exp=%0d", ph_q.size(), exp_ph.size()); end
      foreach (exp_ph[i]) begin
         checks++;
         if (i >= ph_q.size() || ph_q[i] !== exp_ph[i]) begin failures++; $display("FAIL wrap_phase[%0d] exp=%0d", i, exp_ph[i]); end
      end
      if (ph_q.size() == 4) begin
         checks++; if (cb_q[1] !== {IV3, 32'hFFFFFFFF}) begin failures++; $display("FAIL wrap_cb_max got=%h exp=%h", cb_q[1], {IV3, 32'hFFFFFFFF}); end
         checks++; if (cb_q[2] !== {IV3, 32'h0}) begin failures++; $display("FAIL wrap_cb_zero got=%h exp=%h", cb_q[2], {IV3, 32'h0}); end
      end
   endtask

   task automatic test_start_ignored();
      run_job(IV2, K2, 2, 3, 0, 1'b1, 1'b0);
      exp_ph = {3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
      checks++; if (ph_q.size() != exp_ph.size()) begin failures++; $display("FAIL busy_start_phase_count got=%0d exp=%0d", ph_q.size(), exp_ph.size()); end
      foreach (exp_ph[i]) begin
         checks++;
         if (i >= ph_q.size() || ph_q[i] !== exp_ph[i]) begin failures++; $display("FAIL busy_start_phase[%0d] exp=%0d", i, exp_ph[i]); end
      end
      checks++; if (snap_key !== K2) begin failures++; $display("FAIL busy_start_key got=mismatching key exp=K2"); end
      checks++; if (snap_j0 !== {IV2, 32'h1}) begin failures++; $display("FAIL busy_start_j0 got=%h exp=%h", snap_j0, {IV2, 32'h1}); end
      checks++; if (snap_isz !== {64'd256, 64'd384}) begin failures++; $display("FAIL busy_start_isz got=%h exp=%h", snap_isz, {64'd256, 64'd384}); end
      checks++; if (done_pulses != 1) begin failures++; $display("FAIL busy_start_done_pulses got=%0d exp=1", done_pulses); end
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", bus.o_busy); end
   endtask

   task automatic test_reset_mid_job();
      int dones;
      dones = 0;
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_iv = IV0; bus.i_key_schedule = K1;
      bus.i_aad_blocks = 16'd3; bus.i_pt_blocks = 16'd1; bus.i_data_valid = 1'b0;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      bus.i_data_valid = 1'b1; bus.i_data = 128'hA0;
      @(negedge clk);
      bus.i_data_valid = 1'b0;
      checks++; if (bus.o_phase !== 3'd2 || bus.o_data_ready !== 1'b1) begin failures++; $display("FAIL rst_pre_aad got=phase %0d ready %b exp=phase 2 ready 1", bus.o_phase, bus.o_data_ready); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.o_phase !== 3'd0 || bus.o_busy !== 1'b0 || bus.o_data_ready !== 1'b0) begin failures++; $display("FAIL rst_async_ctrl got=phase %0d busy %b ready %b exp=0", bus.o_phase, bus.o_busy, bus.o_data_ready); end
      checks++; if (bus.o_j0 !== 128'd0 || bus.o_aad !== 128'd0 || bus.o_instance_size !== 128'd0) begin failures++; $display("FAIL rst_async_data got=%h/%h/%h exp=0", bus.o_j0, bus.o_aad, bus.o_instance_size); end
      checks++; if (bus.o_key_schedule !== 1408'd0) begin failures++; $display("FAIL rst_async_key got=nonzero exp=0"); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.o_done) dones++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
      run_job(IV3, K1, 1, 1, 0, 1'b0, 1'b0);
      exp_ph = {3'd1, 3'd2, 3'd3, 3'd4};
      checks++; if (ph_q.size() != exp_ph.size()) begin failures++; $display("FAIL rst_rerun_phase_count got=%0d exp=%0d", ph_q.size(), exp_ph.size()); end
      foreach (exp_ph[i]) begin
         checks++;
         if (i >= ph_q.size() || ph_q[i] !== exp_ph[i]) begin failures++; $display("FAIL rst_rerun_phase[%0d] exp=%0d", i, exp_ph[i]); end
      end
      if (ph_q.size() == 4) begin
         checks++; if (cb_q[2] !== {IV3, 32'd2}) begin failures++; $display("FAIL rst_rerun_cb got=%h exp=%h", cb_q[2], {IV3, 32'd2}); end
      end
      checks++; if (done_pulses != 1 || done_gap != PD + 1) begin failures++; $display("FAIL rst_rerun_done got=gap %0d pulses %0d exp=gap %0d pulses 1", done_gap, done_pulses, PD + 1); end
   endtask

   initial begin
      bus.i_start = 1'b0; bus.i_key_schedule = '0; bus.i_iv = '0; bus.i_aad_blocks = '0;
      bus.i_pt_blocks = '0; bus.i_data_valid = 1'b0; bus.i_data = '0; wrap_val = '0;
      test_reset();
      test_zero_length();
      test_back_to_back();
      test_stall();
      test_counter_wrap();
      test_start_ignored();
      test_reset_mid_job();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
